// File: rtl/instr_mem_if.sv
// Fetch/load bus between the CPU front end and the instruction memory.
interface instr_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_fault;
    logic              load_we;
    logic [IDX_W-1:0]  load_idx;
    logic [DATA_W-1:0] load_data;
    logic              init_done;

    modport master (
        output fetch_req, fetch_addr, load_we, load_idx, load_data,
        input  fetch_ready, instr, instr_valid, instr_fault, init_done
    );

    modport slave (
        input  fetch_req, fetch_addr, load_we, load_idx, load_data,
        output fetch_ready, instr, instr_valid, instr_fault, init_done
    );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory: byte-addressed fetch port with 1-cycle registered read,
// word-indexed load port, and a post-reset NOP fill sweep.
module instr_mem_ctrl #(
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 256,
    parameter int                ADDR_W         = 32,
    parameter logic [DATA_W-1:0] NOP_WORD       = {DATA_W{1'b0}},
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    instr_mem_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] instr_q, instr_d;
    logic              fault_q, fault_d;
    logic              valid_q;

    logic              accept;
    logic [IDX_W-1:0]  widx;
    logic              misaligned, out_of_range;
    logic [DATA_W-1:0] rd_word;

    // One shared write port: the sweep owns it in CLEAR, loads own it in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_widx  = bus.load_idx;
        mem_wdata = bus.load_data;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = cnt_q;
                mem_wdata = NOP_WORD;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1))
                    state_d = RUN;
            end
            RUN:     mem_we = bus.load_we;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_widx] <= mem_wdata;
    end

    assign accept       = bus.fetch_req && (state_q == RUN);
    assign widx         = bus.fetch_addr[IDX_W+1:2];
    assign misaligned   = |bus.fetch_addr[1:0];
    assign out_of_range = |bus.fetch_addr[ADDR_W-1:IDX_W+2];
    // Write-first: a same-edge load to the fetched word is forwarded.
    assign rd_word      = (mem_we && (mem_widx == widx)) ? mem_wdata : mem[widx];

    always_comb begin
        instr_d = instr_q;
        fault_d = fault_q;
        if (accept) begin
            if (misaligned || out_of_range) begin
                instr_d = NOP_WORD;
                fault_d = 1'b1;
            end else begin
                instr_d = rd_word;
                fault_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            fault_q <= fault_d;
            valid_q <= accept;
        end
    end

    assign bus.fetch_ready = (state_q == RUN);
    assign bus.init_done   = (state_q == RUN);
    assign bus.instr       = instr_q;
    assign bus.instr_fault = fault_q;
    assign bus.instr_valid = valid_q;
endmodule
